// File: rtl/tcp_tx_sender.sv
// Sends one TCP payload per command: issues tx_meta, retries when the stack reports no space,
// then streams ceil(len/64) beats with a computed tkeep/tlast and returns a status response.
module tcp_tx_sender #(
    parameter int RETRY_DELAY = 64,
    parameter int MAX_RETRY   = 16
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         s_cmd_valid,
    output logic         s_cmd_ready,
    input  logic [31:0]  s_cmd_data,
    output logic         m_tcp_tx_meta_valid,
    input  logic         m_tcp_tx_meta_ready,
    output logic [31:0]  m_tcp_tx_meta_data,
    input  logic         s_tcp_tx_stat_valid,
    output logic         s_tcp_tx_stat_ready,
    input  logic [63:0]  s_tcp_tx_stat_data,
    input  logic         s_axis_tx_tvalid,
    output logic         s_axis_tx_tready,
    input  logic [511:0] s_axis_tx_tdata,
    input  logic [63:0]  s_axis_tx_tkeep,
    input  logic         s_axis_tx_tlast,
    output logic         m_axis_tcp_tx_tvalid,
    input  logic         m_axis_tcp_tx_tready,
    output logic [511:0] m_axis_tcp_tx_tdata,
    output logic [63:0]  m_axis_tcp_tx_tkeep,
    output logic         m_axis_tcp_tx_tlast,
    output logic         m_rsp_valid,
    input  logic         m_rsp_ready,
    output logic [23:0]  m_rsp_data
);

    localparam int DW = (RETRY_DELAY < 2) ? 1 : $clog2(RETRY_DELAY);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {IDLE, META, STAT, DATA, WAIT, RSP} state_t;

    state_t        state;
    logic [15:0]   sid;
    logic [15:0]   len;
    logic [7:0]    status;
    logic [RW-1:0] retry_cnt;
    logic [DW-1:0] delay_cnt;
    logic [9:0]    beat_cnt;

    logic [15:0] cmd_len_m1;
    logic [1:0]  stat_err;
    logic        in_data;
    logic        last_beat;
    logic        beat_hs;
    logic [63:0] keep_last;
    logic        unused_inputs;

    assign cmd_len_m1 = s_cmd_data[31:16] - 16'd1;
    assign stat_err   = s_tcp_tx_stat_data[63:62];
    assign in_data    = (state == DATA);
    assign last_beat  = (beat_cnt == 10'd0);
    assign beat_hs    = in_data && s_axis_tx_tvalid && m_axis_tcp_tx_tready;
    // A partial final beat keeps only the low len mod 64 byte lanes.
    assign keep_last  = (len[5:0] == 6'd0) ? '1 : ((64'h1 << len[5:0]) - 64'h1);

    assign unused_inputs = ^{s_axis_tx_tkeep, s_axis_tx_tlast, s_tcp_tx_stat_data[61:0]};

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            sid       <= '0;
            len       <= '0;
            status    <= '0;
            retry_cnt <= '0;
            delay_cnt <= '0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (s_cmd_valid) begin
                    sid      <= s_cmd_data[15:0];
                    len      <= s_cmd_data[31:16];
                    beat_cnt <= cmd_len_m1[15:6];
                    if (s_cmd_data[31:16] == 16'd0) begin
                        status <= 8'd3;
                        state  <= RSP;
                    end else begin
                        state  <= META;
                    end
                end
                META: if (m_tcp_tx_meta_ready) state <= STAT;
                STAT: if (s_tcp_tx_stat_valid) begin
                    case (stat_err)
                        2'd0: state <= DATA;
                        2'd2: begin
                            if (retry_cnt < RW'(MAX_RETRY)) begin
                                delay_cnt <= DW'(RETRY_DELAY - 1);
                                state     <= WAIT;
                            end else begin
                                status <= 8'd2;
                                state  <= RSP;
                            end
                        end
                        default: begin
                            status <= 8'd1;
                            state  <= RSP;
                        end
                    endcase
                end
                WAIT: begin
                    if (delay_cnt == '0) begin
                        retry_cnt <= retry_cnt + RW'(1);
                        state     <= META;
                    end else begin
                        delay_cnt <= delay_cnt - DW'(1);
                    end
                end
                DATA: if (beat_hs) begin
                    if (last_beat) begin
                        status <= 8'd0;
                        state  <= RSP;
                    end else begin
                        beat_cnt <= beat_cnt - 10'd1;
                    end
                end
                RSP: if (m_rsp_ready) begin
                    retry_cnt <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_cmd_ready          = (state == IDLE);
    assign m_tcp_tx_meta_valid  = (state == META);
    assign m_tcp_tx_meta_data   = {len, sid};
    assign s_tcp_tx_stat_ready  = (state == STAT);
    assign m_rsp_valid          = (state == RSP);
    assign m_rsp_data           = {status, sid};

    // Payload is a pure pass-through gated by the DATA state; nothing is buffered.
    assign s_axis_tx_tready     = in_data && m_axis_tcp_tx_tready;
    assign m_axis_tcp_tx_tvalid = in_data && s_axis_tx_tvalid;
    assign m_axis_tcp_tx_tdata  = s_axis_tx_tdata;
    assign m_axis_tcp_tx_tlast  = in_data && last_beat;
    assign m_axis_tcp_tx_tkeep  = !in_data ? '0 : (last_beat ? keep_last : '1);

endmodule

// File: tb/tb_tcp_tx_sender.sv
// Directed bench for tcp_tx_sender: a table of commands with hand-computed results,
// plus a reset-during-payload sequence.
module tb_tcp_tx_sender;

    localparam int RD = 4;
    localparam int MR = 2;

    logic         aclk = 1'b0;
    logic         areset;
    logic         s_cmd_valid;
    logic         s_cmd_ready;
    logic [31:0]  s_cmd_data;
    logic         m_tcp_tx_meta_valid;
    logic         m_tcp_tx_meta_ready;
    logic [31:0]  m_tcp_tx_meta_data;
    logic         s_tcp_tx_stat_valid;
    logic         s_tcp_tx_stat_ready;
    logic [63:0]  s_tcp_tx_stat_data;
    logic         s_axis_tx_tvalid;
    logic         s_axis_tx_tready;
    logic [511:0] s_axis_tx_tdata;
    logic [63:0]  s_axis_tx_tkeep;
    logic         s_axis_tx_tlast;
    logic         m_axis_tcp_tx_tvalid;
    logic         m_axis_tcp_tx_tready;
    logic [511:0] m_axis_tcp_tx_tdata;
    logic [63:0]  m_axis_tcp_tx_tkeep;
    logic         m_axis_tcp_tx_tlast;
    logic         m_rsp_valid;
    logic         m_rsp_ready;
    logic [23:0]  m_rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    tcp_tx_sender #(.RETRY_DELAY(RD), .MAX_RETRY(MR)) dut (
        .aclk                 (aclk),
        .areset               (areset),
        .s_cmd_valid          (s_cmd_valid),
        .s_cmd_ready          (s_cmd_ready),
        .s_cmd_data           (s_cmd_data),
        .m_tcp_tx_meta_valid  (m_tcp_tx_meta_valid),
        .m_tcp_tx_meta_ready  (m_tcp_tx_meta_ready),
        .m_tcp_tx_meta_data   (m_tcp_tx_meta_data),
        .s_tcp_tx_stat_valid  (s_tcp_tx_stat_valid),
        .s_tcp_tx_stat_ready  (s_tcp_tx_stat_ready),
        .s_tcp_tx_stat_data   (s_tcp_tx_stat_data),
        .s_axis_tx_tvalid     (s_axis_tx_tvalid),
        .s_axis_tx_tready     (s_axis_tx_tready),
        .s_axis_tx_tdata      (s_axis_tx_tdata),
        .s_axis_tx_tkeep      (s_axis_tx_tkeep),
        .s_axis_tx_tlast      (s_axis_tx_tlast),
        .m_axis_tcp_tx_tvalid (m_axis_tcp_tx_tvalid),
        .m_axis_tcp_tx_tready (m_axis_tcp_tx_tready),
        .m_axis_tcp_tx_tdata  (m_axis_tcp_tx_tdata),
        .m_axis_tcp_tx_tkeep  (m_axis_tcp_tx_tkeep),
        .m_axis_tcp_tx_tlast  (m_axis_tcp_tx_tlast),
        .m_rsp_valid          (m_rsp_valid),
        .m_rsp_ready          (m_rsp_ready),
        .m_rsp_data           (m_rsp_data)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [15:0] len;
        logic [15:0] sid;
        int          n_err2;     // leading "no space" stats before final_err
        logic [1:0]  final_err;
        bit          bp;         // random backpressure/valid gaps
        logic [7:0]  exp_status;
        int          exp_meta;
        int          exp_beats;
        logic [63:0] exp_keep;   // tkeep on the final beat
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] pat(input int idx, input logic [15:0] s);
        return {16{16'(idx), s}};
    endfunction

    task automatic idle_inputs();
        s_cmd_valid          = 1'b0;
        s_cmd_data           = '0;
        m_tcp_tx_meta_ready  = 1'b0;
        s_tcp_tx_stat_valid  = 1'b0;
        s_tcp_tx_stat_data   = '0;
        s_axis_tx_tvalid     = 1'b0;
        s_axis_tx_tdata      = '0;
        s_axis_tx_tkeep      = '0;
        s_axis_tx_tlast      = 1'b0;
        m_axis_tcp_tx_tready = 1'b0;
        m_rsp_ready          = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        bit          cmd_pend = 1'b1;
        bit          done = 1'b0;
        bit          any_tready = 1'b0;
        bit          wait_gap = 1'b0;
        bit          prev_meta_v = 1'b0, prev_meta_hs = 1'b0;
        bit          prev_rsp_v = 1'b0, prev_rsp_hs = 1'b0;
        logic [31:0] prev_meta_d = '0;
        logic [23:0] prev_rsp_d = '0;
        logic [1:0]  err;
        int          meta_n = 0, stat_n = 0, beats = 0, src_idx = 0;
        int          last_stat_cyc = -100;
        bit          lb;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge aclk);
            err = (stat_n < v.n_err2) ? 2'd2 : v.final_err;
            s_cmd_valid          = cmd_pend;
            s_cmd_data           = {v.len, v.sid};
            s_tcp_tx_stat_valid  = 1'b1;
            s_tcp_tx_stat_data   = {err, 30'h1234, v.len, v.sid};
            s_axis_tx_tvalid     = v.bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_axis_tx_tdata      = pat(src_idx, v.sid);
            s_axis_tx_tkeep      = 64'h5;
            s_axis_tx_tlast      = (src_idx == 0);
            m_axis_tcp_tx_tready = v.bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            m_tcp_tx_meta_ready  = v.bp ? ($urandom_range(0, 1) != 0) : 1'b1;
            m_rsp_ready          = v.bp ? ($urandom_range(0, 2) == 0) : 1'b1;
            #1;
            if (prev_meta_v && !prev_meta_hs)
                chk("meta_hold", 512'({m_tcp_tx_meta_valid, m_tcp_tx_meta_data}), 512'({1'b1, prev_meta_d}));
            if (prev_rsp_v && !prev_rsp_hs)
                chk("rsp_hold", 512'({m_rsp_valid, m_rsp_data}), 512'({1'b1, prev_rsp_d}));
            if (m_tcp_tx_meta_valid && wait_gap) begin
                chk("retry_gap_ok", 512'((c - last_stat_cyc) >= RD + 1), 512'(1));
                wait_gap = 1'b0;
            end
            if (s_axis_tx_tready) any_tready = 1'b1;
            if (s_cmd_valid && s_cmd_ready) cmd_pend = 1'b0;
            if (m_tcp_tx_meta_valid && m_tcp_tx_meta_ready) begin
                chk("meta_data", 512'(m_tcp_tx_meta_data), 512'({v.len, v.sid}));
                meta_n++;
            end
            if (s_tcp_tx_stat_valid && s_tcp_tx_stat_ready) begin
                stat_n++;
                last_stat_cyc = c;
                if (err == 2'd2) wait_gap = 1'b1;
            end
            if (m_axis_tcp_tx_tvalid && m_axis_tcp_tx_tready) begin
                lb = (beats == v.exp_beats - 1);
                chk("beat_data", m_axis_tcp_tx_tdata, pat(beats, v.sid));
                chk("beat_keep", 512'(m_axis_tcp_tx_tkeep), 512'(lb ? v.exp_keep : 64'hFFFF_FFFF_FFFF_FFFF));
                chk("beat_last", 512'(m_axis_tcp_tx_tlast), 512'(lb));
                beats++;
            end
            if (s_axis_tx_tvalid && s_axis_tx_tready) src_idx++;
            if (m_rsp_valid && m_rsp_ready) begin
                chk("rsp_data", 512'(m_rsp_data), 512'({v.exp_status, v.sid}));
                chk("cmd_ready_in_rsp", 512'(s_cmd_ready), 512'(0));
                done = 1'b1;
            end
            prev_meta_v  = m_tcp_tx_meta_valid;
            prev_meta_hs = m_tcp_tx_meta_valid && m_tcp_tx_meta_ready;
            prev_meta_d  = m_tcp_tx_meta_data;
            prev_rsp_v   = m_rsp_valid;
            prev_rsp_hs  = m_rsp_valid && m_rsp_ready;
            prev_rsp_d   = m_rsp_data;
        end
        chk("txn_done", 512'(done), 512'(1));
        chk("meta_count", 512'(meta_n), 512'(v.exp_meta));
        chk("stat_count", 512'(stat_n), 512'(v.exp_meta));
        chk("beat_count", 512'(beats), 512'(v.exp_beats));
        chk("tready_only_on_success", 512'(any_tready), 512'(v.exp_status == 8'd0));
        @(negedge aclk);
        idle_inputs();
        #1;
        chk("cmd_ready_after_rsp", 512'(s_cmd_ready), 512'(1));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cmd_ready"},  512'(s_cmd_ready), 512'(1));
        chk({tag, "_meta_valid"}, 512'(m_tcp_tx_meta_valid), 512'(0));
        chk({tag, "_stat_ready"}, 512'(s_tcp_tx_stat_ready), 512'(0));
        chk({tag, "_tx_tready"},  512'(s_axis_tx_tready), 512'(0));
        chk({tag, "_tx_tvalid"},  512'(m_axis_tcp_tx_tvalid), 512'(0));
        chk({tag, "_tx_tlast"},   512'(m_axis_tcp_tx_tlast), 512'(0));
        chk({tag, "_rsp_valid"},  512'(m_rsp_valid), 512'(0));
    endtask

    task automatic reset_mid_data();
        int  beats = 0;
        bit  tl_seen = 1'b0;
        for (int c = 0; c < 200 && beats < 3; c++) begin
            @(negedge aclk);
            s_cmd_valid          = (c == 0);
            s_cmd_data           = {16'd640, 16'h0077};
            m_tcp_tx_meta_ready  = 1'b1;
            s_tcp_tx_stat_valid  = 1'b1;
            s_tcp_tx_stat_data   = {2'd0, 30'h0, 16'd640, 16'h0077};
            s_axis_tx_tvalid     = 1'b1;
            s_axis_tx_tdata      = pat(beats, 16'h0077);
            m_axis_tcp_tx_tready = 1'b1;
            m_rsp_ready          = 1'b1;
            #1;
            if (m_axis_tcp_tx_tvalid && m_axis_tcp_tx_tready) begin
                if (m_axis_tcp_tx_tlast) tl_seen = 1'b1;
                beats++;
            end
        end
        chk("reset_setup_beats", 512'(beats), 512'(3));
        @(negedge aclk);
        areset = 1'b1;
        s_axis_tx_tvalid = 1'b0;
        s_cmd_valid = 1'b0;
        #1;
        chk("no_tlast_before_reset", 512'(tl_seen | m_axis_tcp_tx_tlast), 512'(0));
        @(negedge aclk);
        areset = 1'b0;
        s_axis_tx_tvalid = 1'b1;
        #1;
        check_idle_outputs("post_reset");
        @(negedge aclk);
        idle_inputs();
    endtask

    initial begin
        // len, sid, n_err2, final_err, bp, status, metas, beats, final keep
        vecs[0]  = '{16'd130,  16'h0005, 0, 2'd0, 1'b0, 8'd0, 1, 3,  64'h3};
        vecs[1]  = '{16'd64,   16'h0011, 0, 2'd0, 1'b0, 8'd0, 1, 1,  64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2]  = '{16'd0,    16'h0022, 0, 2'd0, 1'b0, 8'd3, 0, 0,  64'h0};
        vecs[3]  = '{16'd1,    16'hABCD, 0, 2'd0, 1'b0, 8'd0, 1, 1,  64'h1};
        vecs[4]  = '{16'd1000, 16'h0102, 0, 2'd0, 1'b1, 8'd0, 1, 16, 64'h0000_00FF_FFFF_FFFF};
        vecs[5]  = '{16'd100,  16'h0007, 0, 2'd1, 1'b0, 8'd1, 1, 0,  64'h0};
        vecs[6]  = '{16'd50,   16'h0008, 0, 2'd3, 1'b0, 8'd1, 1, 0,  64'h0};
        vecs[7]  = '{16'd127,  16'h0009, 2, 2'd0, 1'b0, 8'd0, 3, 2,  64'h7FFF_FFFF_FFFF_FFFF};
        vecs[8]  = '{16'd200,  16'h000A, 5, 2'd2, 1'b0, 8'd2, 3, 0,  64'h0};
        vecs[9]  = '{16'd130,  16'hFFFF, 1, 2'd0, 1'b1, 8'd0, 2, 3,  64'h3};
        vecs[10] = '{16'd100,  16'h0123, 0, 2'd0, 1'b1, 8'd0, 1, 2,  64'h0000_000F_FFFF_FFFF};

        idle_inputs();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        s_tcp_tx_stat_valid = 1'b1;
        s_axis_tx_tvalid = 1'b1;
        m_axis_tcp_tx_tready = 1'b1;
        #1;
        check_idle_outputs("reset");
        @(negedge aclk);
        idle_inputs();

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);
        reset_mid_data();
        for (int i = 8; i < 11; i++) run_txn(vecs[i]);
        run_txn(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
